// File: rtl/fft_ctrl_pkg.sv
// Shared constants, state encoding and digit-sum helper for the 2048-point FFT sequencer.
// Word n lives in bank (digit-sum of n) mod 4, so every butterfly access is conflict-free.
package fft_ctrl_pkg;

    localparam int unsigned N          = 2048;
    localparam int unsigned ADDR_W     = 9;
    localparam int unsigned WORDS      = N / 4;
    localparam int unsigned NUM_STAGES = 6;
    localparam int unsigned R2_STAGE   = NUM_STAGES - 1;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } fsm_e;

    // Sum of four base-4 digits, wrapped to 2 bits.
    function automatic logic [1:0] digit_sum4(input logic [7:0] v);
        return v[7:6] + v[5:4] + v[3:2] + v[1:0];
    endfunction

endpackage

// File: rtl/fft_ctrl_dly.sv
// Fixed-depth shift register carrying read-side context to the write side of the butterfly.
module fft_ctrl_dly #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 13
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] pipe_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < Depth; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/fft_ctrl_seq.sv
// Address/control sequencer for a 2048-point FFT: five radix-4 stages then one dual radix-2 stage,
// ping-ponging between memories A and B.
module fft_ctrl_seq
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned BUT_LAT = 4
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iSTART,
    output logic [1:0]        oBANK_RD_ROT,
    output logic [1:0]        oBANK_WR_ROT,
    output logic [ADDR_W-1:0] oADDR_RD_0,
    output logic [ADDR_W-1:0] oADDR_RD_1,
    output logic [ADDR_W-1:0] oADDR_RD_2,
    output logic [ADDR_W-1:0] oADDR_RD_3,
    output logic [ADDR_W-1:0] oADDR_WR,
    output logic [ADDR_W-1:0] oADDR_COEF,
    output logic              oWE_A,
    output logic              oWE_B,
    output logic              oSOURCE_DATA,
    output logic              oSOURCE_CONT,
    output logic              oBUT_TYPE,
    output logic              oRDY
);

    localparam int unsigned Period = WORDS + BUT_LAT;
    localparam int unsigned PhW    = $clog2(Period);
    localparam int unsigned DlyW   = 1 + ADDR_W + 2 + 1;

    fsm_e              state_q, state_d;
    logic [2:0]        stage_q, stage_d;
    logic [PhW-1:0]    ph_q, ph_d;
    logic [ADDR_W-1:0] rd_addr_q [4];
    logic [ADDR_W-1:0] rd_addr_d [4];
    logic [ADDR_W-1:0] c_q, c_d;
    logic [ADDR_W-1:0] coef_q, coef_d;
    logic [1:0]        rot_q, rot_d;
    logic              valid_q, valid_d;
    logic              src_data_q, src_data_d;
    logic              src_cont_q, src_cont_d;
    logic              but_type_q, but_type_d;
    logic              rdy_q, rdy_d;
    logic              run_d, r2_d;

    logic [DlyW-1:0]   wr_ctx;
    logic              wr_valid, wr_par;
    logic [ADDR_W-1:0] wr_c;
    logic [1:0]        wr_rot;

    // Radix-4 operand j reads {t, j, c[7:2]}; radix-2 operand j reads {j[0], c[8:1]}.
    function automatic logic [ADDR_W-1:0] op_addr(input logic r2, input logic [1:0] j,
                                                  input logic [ADDR_W-1:0] c);
        return r2 ? {j[0], c[8:1]} : {c[8], j, c[7:2]};
    endfunction

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        ph_d    = ph_q;
        unique case (state_q)
            StIdle: begin
                if (iSTART) begin
                    state_d = StRun;
                    stage_d = '0;
                    ph_d    = '0;
                end
            end
            StRun: begin
                if (ph_q == PhW'(Period - 1)) begin
                    ph_d = '0;
                    if (stage_q == 3'(R2_STAGE)) begin
                        state_d = StIdle;
                        stage_d = '0;
                    end else begin
                        stage_d = stage_q + 3'd1;
                    end
                end else begin
                    ph_d = ph_q + PhW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered outputs are derived from the next state so they appear on the same edge.
        run_d      = (state_d == StRun);
        r2_d       = (stage_d == 3'(R2_STAGE));
        valid_d    = run_d && (ph_d < PhW'(WORDS));
        c_d        = valid_d ? ph_d[ADDR_W-1:0] : '0;
        rot_d      = '0;
        coef_d     = '0;
        if (valid_d) begin
            if (r2_d) begin
                rot_d = digit_sum4(c_d[8:1]) + {1'b0, c_d[0]};
            end else begin
                rot_d  = digit_sum4(c_d[7:0]) + {1'b0, c_d[8]};
                coef_d = {1'b0, c_d[7:0]} << {stage_d, 1'b0};
            end
        end
        for (int p = 0; p < 4; p++) begin
            rd_addr_d[p] = valid_d ? op_addr(r2_d, 2'(p) - rot_d, c_d) : '0;
        end
        src_data_d = run_d & stage_d[0];
        src_cont_d = run_d;
        but_type_d = run_d & r2_d;
        rdy_d      = ~run_d;
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q    <= StIdle;
            stage_q    <= '0;
            ph_q       <= '0;
            for (int p = 0; p < 4; p++) begin
                rd_addr_q[p] <= '0;
            end
            c_q        <= '0;
            coef_q     <= '0;
            rot_q      <= '0;
            valid_q    <= 1'b0;
            src_data_q <= 1'b0;
            src_cont_q <= 1'b0;
            but_type_q <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            ph_q       <= ph_d;
            for (int p = 0; p < 4; p++) begin
                rd_addr_q[p] <= rd_addr_d[p];
            end
            c_q        <= c_d;
            coef_q     <= coef_d;
            rot_q      <= rot_d;
            valid_q    <= valid_d;
            src_data_q <= src_data_d;
            src_cont_q <= src_cont_d;
            but_type_q <= but_type_d;
            rdy_q      <= rdy_d;
        end
    end

    fft_ctrl_dly #(
        .Depth (BUT_LAT),
        .Width (DlyW)
    ) u_dly (
        .clk_i  (iCLK),
        .rst_ni (iRESET),
        .d_i    ({valid_q, c_q, rot_q, src_data_q}),
        .q_o    (wr_ctx)
    );

    assign {wr_valid, wr_c, wr_rot, wr_par} = wr_ctx;

    assign oBANK_RD_ROT = rot_q;
    assign oADDR_RD_0   = rd_addr_q[0];
    assign oADDR_RD_1   = rd_addr_q[1];
    assign oADDR_RD_2   = rd_addr_q[2];
    assign oADDR_RD_3   = rd_addr_q[3];
    assign oADDR_COEF   = coef_q;
    assign oSOURCE_DATA = src_data_q;
    assign oSOURCE_CONT = src_cont_q;
    assign oBUT_TYPE    = but_type_q;
    assign oRDY         = rdy_q;
    assign oADDR_WR     = wr_c;
    assign oBANK_WR_ROT = wr_rot;
    // Odd stages read B and write A; even stages the reverse.
    assign oWE_A        = wr_valid & wr_par;
    assign oWE_B        = wr_valid & ~wr_par;

endmodule

// File: tb/tb_fft_ctrl_seq.sv
// Self-checking bench for fft_ctrl_seq against an arithmetic per-cycle reference model.
module tb_fft_ctrl_seq;

    localparam int L         = 4;
    localparam int P         = 512 + L;
    localparam int RunCycles = 6 * P;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] rd_rot, wr_rot;
    logic [8:0] rd0, rd1, rd2, rd3, addr_wr, coef;
    logic       we_a, we_b, src_data, src_cont, but_type, rdy;

    int n_checks = 0;
    int n_bad    = 0;
    int cur_k    = -1;

    always #5 clk = ~clk;

    fft_ctrl_seq #(
        .BUT_LAT (L)
    ) dut (
        .iCLK         (clk),
        .iRESET       (rst_n),
        .iSTART       (start),
        .oBANK_RD_ROT (rd_rot),
        .oBANK_WR_ROT (wr_rot),
        .oADDR_RD_0   (rd0),
        .oADDR_RD_1   (rd1),
        .oADDR_RD_2   (rd2),
        .oADDR_RD_3   (rd3),
        .oADDR_WR     (addr_wr),
        .oADDR_COEF   (coef),
        .oWE_A        (we_a),
        .oWE_B        (we_b),
        .oSOURCE_DATA (src_data),
        .oSOURCE_CONT (src_cont),
        .oBUT_TYPE    (but_type),
        .oRDY         (rdy)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s k=%0d got=%0d exp=%0d", tag, cur_k, got, exp);
        end
    endtask

    function automatic int digsum(input int v);
        int sum = 0;
        int x   = v;
        for (int i = 0; i < 4; i++) begin
            sum += x % 4;
            x   /= 4;
        end
        return sum;
    endfunction

    function automatic int exp_rot(input int s, input int c);
        if (s == 5) return (digsum(c / 2) + c % 2) % 4;
        return (c / 256 + digsum(c % 256)) % 4;
    endfunction

    function automatic int exp_addr(input int s, input int c, input int p);
        int j = (p - exp_rot(s, c) + 4) % 4;
        if (s == 5) return (j % 2) * 256 + c / 2;
        return (c / 256) * 256 + j * 64 + (c % 256) / 4;
    endfunction

    function automatic int exp_coef(input int s, input int c);
        if (s == 5) return 0;
        return ((c % 256) * (1 << (2 * s))) % 512;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_rdy"}, int'(rdy), 1);
        check_eq({tag, "_cont"}, int'(src_cont), 0);
        check_eq({tag, "_src"}, int'(src_data), 0);
        check_eq({tag, "_btype"}, int'(but_type), 0);
        check_eq({tag, "_wea"}, int'(we_a), 0);
        check_eq({tag, "_web"}, int'(we_b), 0);
        check_eq({tag, "_rdrot"}, int'(rd_rot), 0);
        check_eq({tag, "_wrrot"}, int'(wr_rot), 0);
        check_eq({tag, "_rd0"}, int'(rd0), 0);
        check_eq({tag, "_rd1"}, int'(rd1), 0);
        check_eq({tag, "_rd2"}, int'(rd2), 0);
        check_eq({tag, "_rd3"}, int'(rd3), 0);
        check_eq({tag, "_wr"}, int'(addr_wr), 0);
        check_eq({tag, "_coef"}, int'(coef), 0);
    endtask

    // k counts cycles after the start edge; k=0 shows stage 0, c=0.
    task automatic check_cycle(input int k);
        int  s  = k / P;
        int  ph = k % P;
        bit  v  = (ph < 512);
        int  c  = v ? ph : 0;
        int  kw = k - L;
        bit  wv = (kw >= 0) && (kw % P < 512);
        int  sw = wv ? kw / P : 0;
        int  cw = wv ? kw % P : 0;
        cur_k = k;
        check_eq("rdy", int'(rdy), 0);
        check_eq("cont", int'(src_cont), 1);
        check_eq("src", int'(src_data), s % 2);
        check_eq("btype", int'(but_type), int'(s == 5));
        check_eq("rdrot", int'(rd_rot), v ? exp_rot(s, c) : 0);
        check_eq("rd0", int'(rd0), v ? exp_addr(s, c, 0) : 0);
        check_eq("rd1", int'(rd1), v ? exp_addr(s, c, 1) : 0);
        check_eq("rd2", int'(rd2), v ? exp_addr(s, c, 2) : 0);
        check_eq("rd3", int'(rd3), v ? exp_addr(s, c, 3) : 0);
        check_eq("coef", int'(coef), v ? exp_coef(s, c) : 0);
        check_eq("wea", int'(we_a), int'(wv && (sw % 2 == 1)));
        check_eq("web", int'(we_b), int'(wv && (sw % 2 == 0)));
        check_eq("wr", int'(addr_wr), cw);
        check_eq("wrrot", int'(wr_rot), wv ? exp_rot(sw, cw) : 0);
        if (k == 0) check_eq("c0_rd1", int'(rd1), 64);
        if (k == 1) check_eq("c1_rd0", int'(rd0), 192);
        if (k == L) check_eq("first_web", int'(we_b), 1);
        if (k == 2 * P + 1) check_eq("s2_coef", int'(coef), 16);
        if (k == 5 * P + 3) begin
            check_eq("r2_rd1", int'(rd1), 257);
            check_eq("r2_rot", int'(rd_rot), 2);
        end
    endtask

    // abort_k >= 0 asserts reset at that cycle instead of finishing the run.
    task automatic run_check(input int abort_k, input bit spurious);
        int spur_k = int'($urandom_range(1, RunCycles - 3));
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < RunCycles; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check_idle("async_rst");
                return;
            end
            check_cycle(k);
            if (spurious) begin
                if (k == spur_k) start = 1'b1;
                else if (k == spur_k + 1) start = 1'b0;
            end
        end
        @(negedge clk);
        cur_k = RunCycles;
        check_idle("done");
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("in_rst");
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            check_idle("post_rst");
        end
        for (int r = 0; r < 3; r++) begin
            run_check(-1, 1'b1);
            repeat ($urandom_range(0, 5)) begin
                @(negedge clk);
                check_idle("gap");
            end
        end
        run_check(3 * P + int'($urandom_range(0, P - 1)), 1'b0);
        repeat (2) @(negedge clk);
        check_idle("held_rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rst_rel");
        run_check(-1, 1'b0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog k=%0d", cur_k);
        $fatal(1);
    end

endmodule

// File: doc/fft_ctrl_seq.md
Name: fft_ctrl_seq

Overview:
- Address/control sequencer for a 2048-point mixed-radix in-core FFT: 5 radix-4 stages followed by 1 radix-2 stage.
- Data lives in two ping-pong memories, A and B. Each memory has 4 banks of 512 words; word index n maps to bank (digit-sum of n) mod 4, which makes every butterfly access conflict-free.
- The block generates per-bank read addresses, bank rotations, the twiddle address, write address/enables, mux selects and ready. It sits between the external loader/unloader and the butterfly datapath.

Parameters:
- BUT_LAT, 4: cycles from a read-address cycle to the matching write cycle (memory read latency plus butterfly latency); must be ≥1.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous active-low reset.
- iSTART  in  1  one-cycle start pulse, honoured only when idle.
- oBANK_RD_ROT  out  2  butterfly input j is taken from bank (j+rot) mod 4.
- oBANK_WR_ROT  out  2  butterfly output j is written to bank (j+rot) mod 4.
- oADDR_RD_0..oADDR_RD_3  out  9 each  read address of bank 0..3.
- oADDR_WR  out  9  common write address for all 4 banks.
- oADDR_COEF  out  9  twiddle ROM address.
- oWE_A, oWE_B  out  1 each  write enable of memory A or B (all 4 banks).
- oSOURCE_DATA  out  1  read memory: 0=A, 1=B.
- oSOURCE_CONT  out  1  memory control owner: 0=external, 1=this block.
- oBUT_TYPE  out  1  0=radix-4, 1=dual radix-2.
- oRDY  out  1  1=idle/done.

Behaviour:
- Reset values: all addresses and rotations 0; oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT and oBUT_TYPE all 0; oRDY=1. State is IDLE.
- All outputs are registered.
- States: IDLE, RUN.
  - IDLE→RUN on the edge sampling iSTART=1. On that edge: stage s=0, counter c=0, oRDY←0, oSOURCE_CONT←1.
  - iSTART during RUN is ignored.
- Stage timing:
  - Stage period P = 512+BUT_LAT cycles.
  - Read-side outputs show c=0..511 on consecutive cycles, then hold 0 for BUT_LAT cycles.
  - s increments after each period.
- Radix-4 stages (s=0..4), read side:
  - Digit fields: t=c[8]; digits c3=c[7:6], c2=c[5:4], c1=c[3:2], c0=c[1:0].
  - S = (t+c3+c2+c1+c0) mod 4.
  - Operand j (j=0..3) address = {t, j[1:0], c[7:2]}.
  - Bank p receives the address of operand j=(p−S) mod 4.
  - oBANK_RD_ROT=S.
  - oADDR_COEF = (c[7:0]·4^s) mod 512.
  - oBUT_TYPE=0.
- Radix-2 stage (s=5), read side:
  - S = (digit-sum of c[8:1] as four 2-bit digits + c[0]) mod 4.
  - Operand j address = {j[0], c[8:1]}.
  - Bank p receives the address of operand j=(p−S) mod 4.
  - Inputs 0/1 form radix-2 pair A; inputs 2/3 form pair B.
  - oBANK_RD_ROT=S, oADDR_COEF=0, oBUT_TYPE=1.
- Write side, all stages: oADDR_WR, oBANK_WR_ROT and the write enable are delayed copies of c, S and read-valid, delayed by exactly BUT_LAT cycles.
  - Active for exactly 512 cycles per stage.
- Ping-pong memory selection:
  - Even stages: oSOURCE_DATA=0 and write via oWE_B.
  - Odd stages: oSOURCE_DATA=1 and write via oWE_A.
  - The final result ends in memory A, at address c, bank (S+j) mod 4.
- Hazard rule: a stage's first read occurs the cycle after the previous stage's last write.
- Completion: on the edge ending the last write of stage 5, oRDY←1, oSOURCE_CONT←0 and state←IDLE.
  - Start edge to oRDY=1 takes 6·P cycles (3096 at BUT_LAT=4).
  - Back-to-back runs are identical.
- Reset mid-run: all outputs return to their reset values asynchronously; no partial state survives.

Decomposition:
- Package fft_ctrl_pkg holds N=2048, ADDR_W=9, NUM_STAGES=6, R2_STAGE=5, a digit-sum function and a state enum.
- One sub-module, fft_ctrl_dly: a BUT_LAT-deep shift register carrying {valid, c, S, stage parity} to the write side.

Test Plan:
- Reset released with no start → all outputs 0, oRDY=1, for 100 cycles.
- iSTART pulse, stage 0:
  - Cycle after the start edge, c=0: oRDY=0, oSOURCE_CONT=1, RD_0..3 = 0, 64, 128, 192; rot 0; coef 0.
  - c=1: RD = 192, 0, 64, 128; rot 1; coef 1.
- Write side:
  - oWE_B first rises BUT_LAT cycles after the c=0 cycle, with ADDR_WR=0 and WR_ROT=0, and stays high 512 cycles.
  - Stage 1 uses oWE_A with oSOURCE_DATA=1.
  - Stage 2 c=1: coef 16.
- Radix-2 stage, c=3: oBUT_TYPE=1, rot 2, RD = 1, 257, 1, 257; coef 0.
- Completion: oRDY returns to 1 exactly 3096 cycles after the start edge.
  - A second iSTART mid-run has no effect.
  - Three repeated runs give identical traces.
- Assert iRESET low mid-stage 3 → outputs immediately at reset values with oRDY=1; a new start runs from stage 0.
